// File: rtl/pipe_skid_buffer.sv
// Purpose : two-entry elastic stage (main + skid register) with VALID/READY on both sides.
// Latency : 1 cycle from input acceptance to OUT_VALID when the stage is empty or draining.
// Backpr. : IN_READY drops only when both entries are full; it and OUT_* come straight from flops.
//
// Ports:
//   CLOCK / RESET        rising-edge clock, asynchronous active-low reset
//   FLUSH                synchronous clear, discards every stored beat
//   IN_DATA / IN_VALID   producer beat, accepted when IN_VALID & IN_READY
//   IN_READY             stage has room (registered)
//   OUT_DATA / OUT_VALID head beat to the consumer (registered)
//   OUT_READY            consumer takes the head beat this cycle
//   LEVEL                number of stored beats: 0, 1 or 2
module pipe_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [1:0]       LEVEL
);

  // The state encoding doubles as the occupancy count driven on LEVEL.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;   // head beat, drives OUT_DATA
  logic [WIDTH-1:0] skid_q, skid_d;   // second beat, caught while the consumer stalls
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = IN_VALID & in_ready_q;
  assign out_fire = out_valid_q & OUT_READY;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = IN_DATA;
        end
      end

      ST_ONE: begin
        if (in_fire && out_fire) begin
          // Head leaves and the new beat replaces it in the same edge.
          main_d = IN_DATA;
        end else if (in_fire) begin
          // Consumer stalled: park the new beat behind the head.
          state_d = ST_FULL;
          skid_d  = IN_DATA;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end

      ST_FULL: begin
        // IN_READY is low here, so only the output side can move.
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end

      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush drops all stored beats but leaves the data registers alone,
    // so OUT_DATA does not toggle.
    if (FLUSH) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // Handshake outputs are precomputed from the next state so they can be
  // registered without adding a cycle of latency.
  assign out_valid_d = (state_d != ST_EMPTY);
  assign in_ready_d  = (state_d != ST_FULL);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = main_q;
  assign LEVEL     = state_q;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Bench for pipe_skid_buffer: directed steps on an 8-bit instance, then
// random traffic on 1-bit and 32-bit instances, all against a queue model.
module tb_pipe_skid_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic flush_off = 1'b0;

  // 8-bit instance
  logic       flush8 = 1'b0;
  logic [7:0] in_dat8 = '0;
  logic       in_vld8 = 1'b0;
  logic       in_rdy8;
  logic [7:0] out_dat8;
  logic       out_vld8;
  logic       out_rdy8 = 1'b0;
  logic [1:0] lvl8;

  // 1-bit instance
  logic [0:0] in_dat1 = '0;
  logic       in_vld1 = 1'b0;
  logic       in_rdy1;
  logic [0:0] out_dat1;
  logic       out_vld1;
  logic       out_rdy1 = 1'b0;
  logic [1:0] lvl1;

  // 32-bit instance
  logic [31:0] in_dat32 = '0;
  logic        in_vld32 = 1'b0;
  logic        in_rdy32;
  logic [31:0] out_dat32;
  logic        out_vld32;
  logic        out_rdy32 = 1'b0;
  logic [1:0]  lvl32;

  pipe_skid_buffer #(.WIDTH(8)) u_dut8 (
    .CLOCK(clk), .RESET(rst_n), .FLUSH(flush8),
    .IN_DATA(in_dat8), .IN_VALID(in_vld8), .IN_READY(in_rdy8),
    .OUT_DATA(out_dat8), .OUT_VALID(out_vld8), .OUT_READY(out_rdy8),
    .LEVEL(lvl8));

  pipe_skid_buffer #(.WIDTH(1)) u_dut1 (
    .CLOCK(clk), .RESET(rst_n), .FLUSH(flush_off),
    .IN_DATA(in_dat1), .IN_VALID(in_vld1), .IN_READY(in_rdy1),
    .OUT_DATA(out_dat1), .OUT_VALID(out_vld1), .OUT_READY(out_rdy1),
    .LEVEL(lvl1));

  pipe_skid_buffer #(.WIDTH(32)) u_dut32 (
    .CLOCK(clk), .RESET(rst_n), .FLUSH(flush_off),
    .IN_DATA(in_dat32), .IN_VALID(in_vld32), .IN_READY(in_rdy32),
    .OUT_DATA(out_dat32), .OUT_VALID(out_vld32), .OUT_READY(out_rdy32),
    .LEVEL(lvl32));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a two-deep FIFO. Outputs reflect occupancy after the
  // previous edge; at each edge the head may leave and a new beat may enter.
  logic [7:0]  q8[$];
  logic [7:0]  got8[$];
  logic [0:0]  q1[$];
  logic [31:0] q32[$];
  int acc1 = 0, del1 = 0, acc32 = 0, del32 = 0;
  bit inf1, inf32;

  // Call right after an edge (+1); inputs must already be driven.
  task automatic tick8();
    bit inf, outf;
    @(negedge clk);
    check("lvl8", {30'd0, lvl8}, q8.size());
    check("out_vld8", {31'd0, out_vld8}, {31'd0, q8.size() != 0});
    check("in_rdy8", {31'd0, in_rdy8}, {31'd0, q8.size() < 2});
    if (q8.size() != 0) check("out_dat8", {24'd0, out_dat8}, {24'd0, q8[0]});
    inf  = in_vld8 && (q8.size() < 2);
    outf = out_rdy8 && (q8.size() != 0);
    @(posedge clk);
    if (flush8) begin
      q8.delete();
    end else begin
      if (outf) got8.push_back(q8.pop_front());
      if (inf) q8.push_back(in_dat8);
    end
    #1;
  endtask

  task automatic tickr();
    bit of1, of32;
    @(negedge clk);
    check("lvl1", {30'd0, lvl1}, acc1 - del1);
    check("out_vld1", {31'd0, out_vld1}, {31'd0, q1.size() != 0});
    check("in_rdy1", {31'd0, in_rdy1}, {31'd0, q1.size() < 2});
    if (q1.size() != 0) check("out_dat1", {31'd0, out_dat1}, {31'd0, q1[0]});
    check("lvl32", {30'd0, lvl32}, acc32 - del32);
    check("out_vld32", {31'd0, out_vld32}, {31'd0, q32.size() != 0});
    check("in_rdy32", {31'd0, in_rdy32}, {31'd0, q32.size() < 2});
    if (q32.size() != 0) check("out_dat32", out_dat32, q32[0]);
    inf1  = in_vld1 && (q1.size() < 2);
    of1   = out_rdy1 && (q1.size() != 0);
    inf32 = in_vld32 && (q32.size() < 2);
    of32  = out_rdy32 && (q32.size() != 0);
    @(posedge clk);
    if (of1) begin void'(q1.pop_front()); del1++; end
    if (inf1) begin q1.push_back(in_dat1); acc1++; end
    if (of32) begin void'(q32.pop_front()); del32++; end
    if (inf32) begin q32.push_back(in_dat32); acc32++; end
    #1;
  endtask

  initial begin
    // ---- reset state ----
    #1 rst_n = 1'b0;
    #2;
    check("rst_lvl", {30'd0, lvl8}, 32'd0);
    check("rst_out_vld", {31'd0, out_vld8}, 32'd0);
    check("rst_in_rdy", {31'd0, in_rdy8}, 32'd1);
    check("rst_out_dat", {24'd0, out_dat8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- 1: reset mid-stream at LEVEL=2 ----
    in_vld8 = 1'b1; out_rdy8 = 1'b0;
    in_dat8 = 8'h01; tick8();
    in_dat8 = 8'h02; tick8();
    check("fill_lvl", {30'd0, lvl8}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_vld", {31'd0, out_vld8}, 32'd0);
    check("mid_rst_lvl", {30'd0, lvl8}, 32'd0);
    check("mid_rst_in_rdy", {31'd0, in_rdy8}, 32'd1);
    q8.delete();
    in_vld8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_vld8 = 1'b1; in_dat8 = 8'h11; out_rdy8 = 1'b1;
    tick8();
    check("post_rst_vld", {31'd0, out_vld8}, 32'd1);
    check("post_rst_dat", {24'd0, out_dat8}, 32'h11);

    // ---- 2: streaming 0x00..0x0F ----
    got8.delete();
    for (int i = 0; i < 16; i++) begin
      in_dat8 = i[7:0];
      tick8();
      check("stream_vld", {31'd0, out_vld8}, 32'd1);
      check("stream_dat", {24'd0, out_dat8}, i);
      check("stream_lvl", {30'd0, lvl8}, 32'd1);
    end
    in_vld8 = 1'b0;
    tick8();
    check("stream_count", got8.size(), 32'd17);
    for (int i = 0; i < 16; i++)
      if (got8.size() > i + 1) check("stream_order", {24'd0, got8[i+1]}, i);

    // ---- 3: backpressure ----
    got8.delete();
    out_rdy8 = 1'b0; in_vld8 = 1'b1;
    in_dat8 = 8'hA1; tick8();
    check("bp_lvl1", {30'd0, lvl8}, 32'd1);
    in_dat8 = 8'hA2; tick8();
    check("bp_lvl2", {30'd0, lvl8}, 32'd2);
    check("bp_in_rdy", {31'd0, in_rdy8}, 32'd0);
    in_dat8 = 8'hA3; tick8();
    check("bp_held_lvl", {30'd0, lvl8}, 32'd2);
    check("bp_held_dat", {24'd0, out_dat8}, 32'hA1);
    out_rdy8 = 1'b1;
    tick8();
    tick8();
    in_vld8 = 1'b0;
    tick8();
    check("bp_count", got8.size(), 32'd3);
    if (got8.size() == 3) begin
      check("bp_ord0", {24'd0, got8[0]}, 32'hA1);
      check("bp_ord1", {24'd0, got8[1]}, 32'hA2);
      check("bp_ord2", {24'd0, got8[2]}, 32'hA3);
    end

    // ---- 4: simultaneous in/out in ONE ----
    out_rdy8 = 1'b0; in_vld8 = 1'b1; in_dat8 = 8'h55;
    tick8();
    check("sim_pre_dat", {24'd0, out_dat8}, 32'h55);
    in_dat8 = 8'h66; out_rdy8 = 1'b1;
    tick8();
    check("sim_lvl", {30'd0, lvl8}, 32'd1);
    check("sim_dat", {24'd0, out_dat8}, 32'h66);
    check("sim_vld", {31'd0, out_vld8}, 32'd1);
    in_vld8 = 1'b0;
    tick8();

    // ---- 5: flush at LEVEL=2 with a beat offered ----
    out_rdy8 = 1'b0; in_vld8 = 1'b1;
    in_dat8 = 8'hB1; tick8();
    in_dat8 = 8'hB2; tick8();
    in_dat8 = 8'hB3; flush8 = 1'b1; tick8();
    flush8 = 1'b0; in_vld8 = 1'b0;
    check("fl_lvl", {30'd0, lvl8}, 32'd0);
    check("fl_out_vld", {31'd0, out_vld8}, 32'd0);
    check("fl_in_rdy", {31'd0, in_rdy8}, 32'd1);
    check("fl_out_dat_kept", {24'd0, out_dat8}, 32'hB1);
    got8.delete();
    out_rdy8 = 1'b1;
    repeat (4) tick8();
    check("fl_none_delivered", got8.size(), 32'd0);
    out_rdy8 = 1'b0;

    // ---- 6: random traffic, WIDTH=1 and WIDTH=32 ----
    inf1 = 1'b0; inf32 = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      // A pending beat stays offered, unchanged, until it is accepted.
      if (!in_vld1 || inf1) begin
        in_vld1 = ($urandom_range(0, 2) != 0);
        in_dat1 = 1'($urandom);
      end
      if (!in_vld32 || inf32) begin
        in_vld32 = ($urandom_range(0, 1) != 0);
        in_dat32 = $urandom;
      end
      out_rdy1  = ($urandom_range(0, 1) != 0);
      out_rdy32 = ($urandom_range(0, 3) != 0);
      tickr();
    end
    in_vld1 = 1'b0; in_vld32 = 1'b0;
    out_rdy1 = 1'b1; out_rdy32 = 1'b1;
    repeat (3) tickr();
    check("rnd_drain1", acc1 - del1, 32'd0);
    check("rnd_drain32", acc32 - del32, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
